// File: rtl/cache_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// cache_ctrl_fsm_if
//   Bundle between the cache sequencing controller and its surroundings: the
//   CPU memory port, the 2-way cache datapath and the physical-memory adaptor.
//
//   Select encodings used on the datapath control lines are declared here so
//   the controller, the datapath and any bench share one definition.
//
//   Signals (direction as seen by the controller, modport master):
//     in : mem_read, mem_write      CPU request, held until mem_resp
//     in : hit, dirty0, dirty1, lru datapath status for the indexed set
//     in : pmem_resp                adaptor completion pulse
//     out: mem_resp                 one-cycle completion pulse to the CPU
//     out: load, valid, dirty, lru_load, write_en_sel, write_data_sel,
//          ram_addr_sel             datapath array controls
//     out: pmem_read, pmem_write    line fill / write-back requests
//
//   Handshake semantics: a CPU request (mem_read/mem_write) is a level that
//   the requester holds until the single-cycle mem_resp pulse; the controller
//   answers each request exactly once. pmem_read/pmem_write are levels the
//   controller holds until the adaptor pulses pmem_resp, dropped the next
//   cycle; they are never high together, and pmem_resp is ignored while
//   neither is high.
//
//   The modport slave is the view of the environment (CPU + datapath +
//   adaptor) driving the controller.
// -----------------------------------------------------------------------------

typedef enum logic [1:0] {
  ALL_DIS = 2'd0,
  ALL_EN  = 2'd1,
  CPU_EN  = 2'd2
} write_en_sel_t;

typedef enum logic {
  CPU_DATA = 1'b0,
  RAM_DATA = 1'b1
} write_data_sel_t;

typedef enum logic {
  CPU_ADDR = 1'b0,
  TAG_ADDR = 1'b1
} ram_addr_sel_t;

interface cache_ctrl_fsm_if;
  logic            mem_read;
  logic            mem_write;
  logic            mem_resp;
  logic            hit;
  logic            dirty0;
  logic            dirty1;
  logic            lru;
  logic            load;
  logic            valid;
  logic            dirty;
  logic            lru_load;
  write_en_sel_t   write_en_sel;
  write_data_sel_t write_data_sel;
  ram_addr_sel_t   ram_addr_sel;
  logic            pmem_read;
  logic            pmem_write;
  logic            pmem_resp;

  modport master (
    input  mem_read, mem_write, hit, dirty0, dirty1, lru, pmem_resp,
    output mem_resp, load, valid, dirty, lru_load,
           write_en_sel, write_data_sel, ram_addr_sel,
           pmem_read, pmem_write
  );

  modport slave (
    output mem_read, mem_write, hit, dirty0, dirty1, lru, pmem_resp,
    input  mem_resp, load, valid, dirty, lru_load,
           write_en_sel, write_data_sel, ram_addr_sel,
           pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// cache_ctrl_fsm
//   Sequencing controller for a 2-way set-associative cache. Turns CPU
//   read/write requests into tag-check, write-back, allocate and re-read
//   sequences, drives every datapath control and runs the line-granular
//   handshake with the physical-memory adaptor.
//
//   Ports:
//     clk          clock, rising edge
//     rst          asynchronous active-low reset
//     bus          cache_ctrl_fsm_if.master (CPU, datapath and adaptor lines)
//     o_dbg_state  current FSM state (state_t encoding) for observation
//   Optional (macro CACHE_PERF_EN defined):
//     CNT_WIDTH    counter width parameter
//     hit_count    first-pass hits, saturating
//     miss_count   tag-check misses, saturating
//     wb_count     write-backs started, saturating
//
//   All outputs decode from the registered state plus hit/lru/dirty/pmem_resp;
//   the CPU request lines only steer the next state and the write/read choice
//   on a hit, so there is no path from mem_read/mem_write to pmem_*.
// -----------------------------------------------------------------------------
module cache_ctrl_fsm
`ifdef CACHE_PERF_EN
#(
  parameter int CNT_WIDTH = 32
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  cache_ctrl_fsm_if.master  bus,
  output logic [2:0]        o_dbg_state
`ifdef CACHE_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_WRITEBACK = 3'd2,
    S_ALLOCATE  = 3'd3,
    S_REREAD    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_req;
  logic w_victim_dirty;

  assign w_req          = bus.mem_read | bus.mem_write;
  assign w_victim_dirty = bus.lru ? bus.dirty1 : bus.dirty0;
  assign o_dbg_state    = r_state;

  // State register. Reset is asynchronous so pmem_* drop the moment rst
  // falls, even in the middle of a line transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (bus.hit)             w_next = S_IDLE;
        else if (w_victim_dirty) w_next = S_WRITEBACK;
        else                     w_next = S_ALLOCATE;
      end
      S_WRITEBACK: begin
        if (bus.pmem_resp) w_next = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        if (bus.pmem_resp) w_next = S_REREAD;
      end
      S_REREAD: begin
        // Arrays now present the filled set; the next CHECK hits and, for a
        // write miss, merges the CPU data into the freshly filled line.
        w_next = S_CHECK;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.mem_resp       = 1'b0;
    bus.load           = 1'b0;
    bus.valid          = 1'b0;
    bus.dirty          = 1'b0;
    bus.lru_load       = 1'b0;
    bus.write_en_sel   = ALL_DIS;
    bus.write_data_sel = CPU_DATA;
    bus.ram_addr_sel   = CPU_ADDR;
    bus.pmem_read      = 1'b0;
    bus.pmem_write     = 1'b0;
    case (r_state)
      S_CHECK: begin
        if (bus.hit) begin
          bus.mem_resp = 1'b1;
          bus.lru_load = 1'b1;
          // A simultaneous read+write request is served as a write.
          if (bus.mem_write) begin
            bus.load           = 1'b1;
            bus.valid          = 1'b1;
            bus.dirty          = 1'b1;
            bus.write_en_sel   = CPU_EN;
            bus.write_data_sel = CPU_DATA;
          end
        end
      end
      S_WRITEBACK: begin
        bus.ram_addr_sel = TAG_ADDR;
        bus.pmem_write   = 1'b1;
      end
      S_ALLOCATE: begin
        bus.ram_addr_sel = CPU_ADDR;
        bus.pmem_read    = 1'b1;
        // Capture the line in the same cycle the adaptor presents it.
        if (bus.pmem_resp) begin
          bus.load           = 1'b1;
          bus.valid          = 1'b1;
          bus.dirty          = 1'b0;
          bus.write_en_sel   = ALL_EN;
          bus.write_data_sel = RAM_DATA;
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_PERF_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Marks the CHECK that follows a refill so its guaranteed hit is not
  // counted as a hit; the original miss was already counted.
  logic r_refill;

  logic w_hit_ev;
  logic w_miss_ev;
  logic w_wb_ev;

  assign w_hit_ev  = (r_state == S_CHECK) &  bus.hit & ~r_refill;
  assign w_miss_ev = (r_state == S_CHECK) & ~bus.hit;
  assign w_wb_ev   = w_miss_ev & w_victim_dirty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_refill   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (r_state == S_REREAD)     r_refill <= 1'b1;
      else if (r_state == S_CHECK) r_refill <= 1'b0;

      if (w_hit_ev  && (hit_count  != '1)) hit_count  <= hit_count  + CNT_ONE;
      if (w_miss_ev && (miss_count != '1)) miss_count <= miss_count + CNT_ONE;
      if (w_wb_ev   && (wb_count   != '1)) wb_count   <= wb_count   + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl_fsm
//   Transaction-level reference: each CPU request is expanded from the
//   sequencing rules into a cycle-by-cycle list of expected controller
//   outputs (exp_q) together with the environment inputs to apply in those
//   cycles (stim_q). Latencies of the adaptor are chosen per transaction.
// -----------------------------------------------------------------------------
module tb_cache_ctrl_fsm;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_fsm_if bus_if ();
  logic [2:0] dbg_state;

`ifdef CACHE_PERF_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  cache_ctrl_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if.master),
    .o_dbg_state (dbg_state)
`ifdef CACHE_PERF_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .wb_count    (wb_count)
`endif
  );

  // Observed output vector:
  // {mem_resp, load, valid, dirty, lru_load, write_en_sel[1:0],
  //  write_data_sel, ram_addr_sel, pmem_read, pmem_write}
  logic [10:0] obs_v;
  assign obs_v = {bus_if.mem_resp, bus_if.load, bus_if.valid, bus_if.dirty,
                  bus_if.lru_load, bus_if.write_en_sel, bus_if.write_data_sel,
                  bus_if.ram_addr_sel, bus_if.pmem_read, bus_if.pmem_write};

  function automatic logic [10:0] ev(input logic resp, ld, vl, dt, lru_ld,
                                     input logic [1:0] we, input logic wd, ra,
                                     input logic pr, pw);
    return {resp, ld, vl, dt, lru_ld, we, wd, ra, pr, pw};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic rd;
    logic wr;
    logic hit;
    logic d0;
    logic d1;
    logic lru;
    logic presp;
  } stim_t;

  stim_t       stim_q[$];
  logic [10:0] exp_q[$];
  logic [10:0] def_v;
  int          total  = 0;
  int          passed = 0;
  int          cyc    = 0;
  string       step   = "";
  int          mdl_hit  = 0;
  int          mdl_miss = 0;
  int          mdl_wb   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input stim_t s, input logic [10:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    bus_if.mem_read  = s.rd;
    bus_if.mem_write = s.wr;
    bus_if.hit       = s.hit;
    bus_if.dirty0    = s.d0;
    bus_if.dirty1    = s.d1;
    bus_if.lru       = s.lru;
    bus_if.pmem_resp = s.presp;
  endtask

  // Apply inputs just after the rising edge, compare mid-cycle.
  task automatic run_cycles(input int n);
    stim_t       s;
    logic [10:0] e;
    for (int i = 0; i < n; i++) begin
      if (stim_q.size() == 0) break;
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(posedge clk);
      #1;
      drive(s);
      @(negedge clk);
      check($sformatf("%s_c%0d", step, cyc), {21'd0, obs_v}, {21'd0, e});
      cyc++;
    end
  endtask

  // ---------------- driver tasks / reference model ----------------
  task automatic enq_idle(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s       = '0;
      s.hit   = 1'($urandom_range(0, 1));
      s.presp = 1'($urandom_range(0, 1));
      s.d0    = 1'($urandom_range(0, 1));
      push(s, def_v);
    end
  endtask

  // One CPU request; cycle 0 is the cycle it is first seen by an idle controller.
  task automatic enq_txn(input logic rd, wr, h, d0, d1, lr,
                         input int wb_lat, fill_lat);
    stim_t       s;
    logic        vd;
    logic [10:0] hv;
    vd = lr ? d1 : d0;
    hv = wr ? ev(1, 1, 1, 1, 1, CPU_EN,  CPU_DATA, CPU_ADDR, 0, 0)
            : ev(1, 0, 0, 0, 1, ALL_DIS, CPU_DATA, CPU_ADDR, 0, 0);
    s.rd = rd; s.wr = wr; s.d0 = d0; s.d1 = d1; s.lru = lr;
    // request seen in idle
    s.hit = 1'($urandom_range(0, 1)); s.presp = 1'($urandom_range(0, 1));
    push(s, def_v);
    // tag check
    s.hit = h; s.presp = 1'($urandom_range(0, 1));
    push(s, h ? hv : def_v);
    if (!h) begin
      mdl_miss++;
      if (vd) begin
        mdl_wb++;
        for (int i = 0; i < wb_lat; i++) begin
          s.hit = 1'($urandom_range(0, 1)); s.presp = (i == wb_lat - 1);
          push(s, ev(0, 0, 0, 0, 0, ALL_DIS, CPU_DATA, TAG_ADDR, 0, 1));
        end
      end
      for (int i = 0; i < fill_lat; i++) begin
        s.hit = 1'($urandom_range(0, 1)); s.presp = (i == fill_lat - 1);
        push(s, (i == fill_lat - 1) ? ev(0, 1, 1, 0, 0, ALL_EN, RAM_DATA, CPU_ADDR, 1, 0)
                                    : ev(0, 0, 0, 0, 0, ALL_DIS, CPU_DATA, CPU_ADDR, 1, 0));
      end
      // re-read, then the check that now hits
      s.hit = 1'($urandom_range(0, 1)); s.presp = 1'($urandom_range(0, 1));
      push(s, def_v);
      s.hit = 1'b1; s.presp = 1'($urandom_range(0, 1));
      push(s, hv);
    end else begin
      mdl_hit++;
    end
  endtask

  task automatic run_txn(input string nm, input logic rd, wr, h, d0, d1, lr,
                         input int wb_lat, fill_lat);
    step = nm;
    cyc  = 0;
    enq_txn(rd, wr, h, d0, d1, lr, wb_lat, fill_lat);
    run_cycles(stim_q.size());
  endtask

  task automatic run_idle(input int n);
    step = "idle";
    cyc  = 0;
    enq_idle(n);
    run_cycles(stim_q.size());
  endtask

`ifdef CACHE_PERF_EN
  task automatic check_counters(input string nm);
    check({nm, "_hit_count"},  hit_count,  mdl_hit);
    check({nm, "_miss_count"}, miss_count, mdl_miss);
    check({nm, "_wb_count"},   wb_count,   mdl_wb);
  endtask
`endif

  // ---------------- directed + random sequence ----------------
  initial begin
    def_v = ev(0, 0, 0, 0, 0, ALL_DIS, CPU_DATA, CPU_ADDR, 0, 0);
    rst   = 1'b0;
    drive('0);

    // reset state
    #2;
    check("reset_outputs", {21'd0, obs_v}, {21'd0, def_v});
`ifdef CACHE_PERF_EN
    check_counters("reset");
`endif
    @(negedge clk);
    rst = 1'b1;

    // clean read miss, adaptor answers 4 cycles after pmem_read rises
    run_txn("clean_read_miss", 1, 0, 0, 0, 0, 0, 0, 4);
`ifdef CACHE_PERF_EN
    check_counters("after_clean_miss");
`endif
    run_idle(2);
    run_txn("read_hit",        1, 0, 1, 0, 0, 0, 0, 0);
    run_txn("write_hit_way1",  0, 1, 1, 1, 0, 1, 0, 0);
    run_idle(1);
    run_txn("dirty_write_miss", 0, 1, 0, 0, 1, 1, 3, 2);
`ifdef CACHE_PERF_EN
    check_counters("after_dirty_miss");
`endif
    run_txn("rd_wr_hit",       1, 1, 1, 0, 0, 0, 0, 0);
    run_txn("dirty_miss_way0", 1, 0, 0, 1, 0, 0, 1, 1);
    run_txn("clean_miss_lru1", 0, 1, 0, 1, 0, 1, 0, 1);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      run_txn($sformatf("rand%0d", t), rd, wr,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
      run_idle(int'($urandom_range(0, 2)));
    end
`ifdef CACHE_PERF_EN
    check_counters("after_random");
`endif

    // reset in the middle of a fill
    step = "rst_in_alloc";
    cyc  = 0;
    enq_txn(1, 0, 0, 0, 0, 0, 0, 4);
    run_cycles(3);
    check("alloc_pmem_read_before_rst", {31'd0, bus_if.pmem_read}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_pmem_read_drop", {31'd0, bus_if.pmem_read}, 32'd0);
    check("rst_outputs", {21'd0, obs_v}, {21'd0, def_v});
    stim_q.delete();
    exp_q.delete();
    mdl_hit = 0; mdl_miss = 0; mdl_wb = 0;
    drive('0);
`ifdef CACHE_PERF_EN
    check_counters("mid_reset");
`endif
    @(negedge clk);
    rst = 1'b1;
    run_idle(3);
    run_txn("post_rst_read_hit",  1, 0, 1, 0, 0, 0, 0, 0);
    run_txn("post_rst_read_miss", 1, 0, 0, 0, 0, 0, 0, 2);
`ifdef CACHE_PERF_EN
    check_counters("final");
`endif

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_fsm.md
# cache_ctrl_fsm

Sequencing controller for the 2-way set-associative cache datapath: turns CPU read/write requests into tag-check, write-back, allocate and re-read sequences. Drives every datapath control input (array loads, write-enable/data/address selects, valid/dirty/LRU updates) and runs the line-granular handshake to the physical-memory adaptor. Sits between the CPU memory port and the 256-bit cacheline bus, one instance per cache.

## Interface
- CNT_WIDTH, 32, width of each performance counter (used only with CACHE_PERF_EN)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to CPU
- hit  in  1  datapath tag-match, valid in CHECK
- dirty0, dirty1  in  1  dirty bits of ways 0/1 at the indexed set
- lru  in  1  LRU way at the indexed set (victim way)
- load  out  1  load valid/dirty/tag of the selected way
- valid, dirty  out  1  values written to the valid/dirty arrays
- lru_load  out  1  update LRU array
- write_en_sel  out  write_en_sel_t  ALL_DIS / ALL_EN / CPU_EN
- write_data_sel  out  write_data_sel_t  CPU_DATA / RAM_DATA
- ram_addr_sel  out  ram_addr_sel_t  CPU_ADDR / TAG_ADDR
- pmem_read  out  1  line fill request to memory adaptor
- pmem_write  out  1  line write-back request to memory adaptor
- pmem_resp  in  1  adaptor completion pulse
- hit_count, miss_count, wb_count  out  CNT_WIDTH  performance counters (CACHE_PERF_EN only)

## Operation
- States: IDLE, CHECK, WRITEBACK, ALLOCATE, REREAD. Default outputs every state: load=0, valid=0, dirty=0, lru_load=0, write_en_sel=ALL_DIS, write_data_sel=CPU_DATA, ram_addr_sel=CPU_ADDR, pmem_read=0, pmem_write=0, mem_resp=0.
- IDLE: req = mem_read|mem_write; req -> CHECK (datapath reads arrays this edge).
- CHECK, hit: mem_resp=1, lru_load=1; if mem_write additionally load=1, valid=1, dirty=1, write_en_sel=CPU_EN, write_data_sel=CPU_DATA. -> IDLE.
- CHECK, miss: victim_dirty = lru ? dirty1 : dirty0. victim_dirty -> WRITEBACK, else -> ALLOCATE. No outputs asserted.
- WRITEBACK: ram_addr_sel=TAG_ADDR, pmem_write=1 until pmem_resp; on pmem_resp -> ALLOCATE.
- ALLOCATE: ram_addr_sel=CPU_ADDR, pmem_read=1; on pmem_resp same cycle: load=1, valid=1, dirty=0, write_en_sel=ALL_EN, write_data_sel=RAM_DATA -> REREAD.
- REREAD: no outputs; arrays re-read the filled set -> CHECK (now hits; write-miss merges CPU data there).
- mem_read and mem_write both high: treated as write.
- pmem_resp outside WRITEBACK/ALLOCATE: ignored.
- CPU dropping request before mem_resp: protocol violation; controller completes current sequence regardless.

## Timing
- Reset (rst=0): state=IDLE immediately, all outputs at defaults above, counters 0; pmem_read/pmem_write drop asynchronously mid-transfer; adaptor must abort on their deassertion.
- Hit latency: request seen in IDLE at cycle 0, mem_resp in cycle 1.
- Clean miss: CHECK cycle 1, ALLOCATE from cycle 2 until pmem_resp at cycle k, REREAD k+1, mem_resp at k+2.
- Dirty miss: WRITEBACK from cycle 2 until pmem_resp at w, ALLOCATE w+1..k, REREAD k+1, mem_resp k+2.
- pmem_read/pmem_write are level signals, held every cycle until pmem_resp, deasserted the cycle after; never both high.
- All outputs are Moore/Mealy from registered state plus hit/lru/dirty/pmem_resp; no combinational path from mem_read/mem_write to pmem_*.

## Configuration
- CACHE_PERF_EN defined: hit_count increments on each CHECK with hit and mem_resp, but not for the post-REREAD CHECK of a miss; miss_count increments on each CHECK miss; wb_count on each WRITEBACK entry. Saturate at all-ones; clear on reset.
- Undefined: counter ports and logic absent.

## Test plan
- Read hit: preload way0 valid, tag match; mem_read at cycle 0 -> mem_resp cycle 1, lru_load=1, load=0, no pmem activity.
- Write hit way1: mem_write -> cycle 1 load=1, valid=1, dirty=1, write_en_sel=CPU_EN, mem_resp=1.
- Clean read miss, adaptor responds 4 cycles after pmem_read rises -> pmem_read high cycles 2-5, load/ALL_EN/RAM_DATA at cycle 5, mem_resp cycle 7; miss_count=1, hit_count=0.
- Dirty write miss (lru=1, dirty1=1): pmem_write with TAG_ADDR until resp, then pmem_read with CPU_ADDR, final CHECK writes dirty=1; wb_count=1.
- rst low during ALLOCATE -> pmem_read=0 same cycle, state IDLE, mem_resp never pulses; next read completes normally.
- Simultaneous mem_read=mem_write=1 on hit -> write path taken (dirty=1, CPU_EN).
